// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file read path.
// Contents: register select codes (8-bit halves AL..BH, 16-bit regs AX..DI),
// default select/data widths, and the read arbiter state encoding.
package regfile_pkg;

  localparam int RF_SW = 4;
  localparam int RF_DW = 16;

  localparam logic [RF_SW-1:0] REG_AL = 4'd0;
  localparam logic [RF_SW-1:0] REG_CL = 4'd1;
  localparam logic [RF_SW-1:0] REG_DL = 4'd2;
  localparam logic [RF_SW-1:0] REG_BL = 4'd3;
  localparam logic [RF_SW-1:0] REG_AH = 4'd4;
  localparam logic [RF_SW-1:0] REG_CH = 4'd5;
  localparam logic [RF_SW-1:0] REG_DH = 4'd6;
  localparam logic [RF_SW-1:0] REG_BH = 4'd7;
  localparam logic [RF_SW-1:0] REG_AX = 4'd8;
  localparam logic [RF_SW-1:0] REG_CX = 4'd9;
  localparam logic [RF_SW-1:0] REG_DX = 4'd10;
  localparam logic [RF_SW-1:0] REG_BX = 4'd11;
  localparam logic [RF_SW-1:0] REG_SP = 4'd12;
  localparam logic [RF_SW-1:0] REG_BP = 4'd13;
  localparam logic [RF_SW-1:0] REG_SI = 4'd14;
  localparam logic [RF_SW-1:0] REG_DI = 4'd15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FROZEN = 2'd2
  } state_t;

endpackage

// File: rtl/regfile_read_arbiter_if.sv
// Bus between the read arbiter and its environment.
//   REQ/REQ_SEL/HOLD : requester side inputs (per-requester request + select code, freeze)
//   GNT              : one-hot grant back to requesters
//   MUX_SEL/MUX_OUT  : select code to, and data from, the 16:1 register read mux
//   RDATA/RVALID/RID : returned read data tagged with requester index
//   BUSY             : grant or return in flight
// slave = arbiter side, master = environment side.
interface regfile_read_arbiter_if
  import regfile_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = 2,
  parameter int DW    = RF_DW,
  parameter int SW    = RF_SW
) ();
  logic [N_REQ-1:0]    REQ;
  logic [N_REQ*SW-1:0] REQ_SEL;
  logic                HOLD;
  logic [N_REQ-1:0]    GNT;
  logic [SW-1:0]       MUX_SEL;
  logic [DW-1:0]       MUX_OUT;
  logic [DW-1:0]       RDATA;
  logic                RVALID;
  logic [IDW-1:0]      RID;
  logic                BUSY;

  modport slave (
    input  REQ, REQ_SEL, HOLD, MUX_OUT,
    output GNT, MUX_SEL, RDATA, RVALID, RID, BUSY
  );

  modport master (
    output REQ, REQ_SEL, HOLD, MUX_OUT,
    input  GNT, MUX_SEL, RDATA, RVALID, RID, BUSY
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   elig   : eligible requester vector
//   ptr    : index where the search starts (ascending, wrapping)
//   winner : first eligible index at or after ptr
//   any    : at least one requester eligible
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] elig,
  input  logic [IDW-1:0]   ptr,
  output logic [IDW-1:0]   winner,
  output logic             any
);
  localparam int PW = $clog2(N_REQ);

  logic [PW-1:0] idx;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = PW'((int'(ptr) + i) % N_REQ);
      if (!any && elig[idx]) begin
        any    = 1'b1;
        winner = IDW'(idx);
      end
    end
  end
endmodule

// File: rtl/regfile_read_arbiter.sv
// Round-robin sharing of the single register-file read port.
//   CLK/RST : clock, asynchronous active-high reset
//   bus     : requester handshake, read-mux select/data, tagged read return
// Two-stage pipeline: grant edge registers GNT/MUX_SEL/owner, the next edge
// captures MUX_OUT into RDATA with RVALID. One read per cycle in aggregate.
module regfile_read_arbiter
  import regfile_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = 2,
  parameter int DW    = RF_DW,
  parameter int SW    = RF_SW
) (
  input logic                   CLK,
  input logic                   RST,
  regfile_read_arbiter_if.slave bus
);
  logic [N_REQ-1:0] elig;
  logic [IDW-1:0]   winner;
  logic             any;
  logic             grant;
  logic             vld_p1;

  logic [N_REQ-1:0] gnt_p1_q, gnt_p1_d;
  logic [SW-1:0]    mux_sel_p1_q, mux_sel_p1_d;
  logic [IDW-1:0]   gid_p1_q, gid_p1_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             vld_p2_q, vld_p2_d;
  logic [DW-1:0]    rdata_p2_q, rdata_p2_d;
  logic [IDW-1:0]   rid_p2_q, rid_p2_d;
  state_t           state_q, state_d;

  // Last cycle's grantee is masked so a still-high REQ is not re-granted back to back.
  assign elig = bus.REQ & ~gnt_p1_q;

  rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_rr (
    .elig   (elig),
    .ptr    (ptr_q),
    .winner (winner),
    .any    (any)
  );

  assign grant  = any & ~bus.HOLD;
  assign vld_p1 = |gnt_p1_q;

  always_comb begin
    // stage p1: grant, mux select, owner tag, pointer advance
    gnt_p1_d     = grant ? (N_REQ'(1) << winner) : '0;
    mux_sel_p1_d = grant ? bus.REQ_SEL[int'(winner)*SW +: SW] : mux_sel_p1_q;
    gid_p1_d     = grant ? winner : gid_p1_q;
    ptr_d        = ptr_q;
    if (grant) begin
      ptr_d = (int'(winner) == N_REQ-1) ? '0 : winner + IDW'(1);
    end

    // stage p2: capture mux output while MUX_SEL is driving it
    vld_p2_d   = vld_p1;
    rdata_p2_d = vld_p1 ? bus.MUX_OUT : rdata_p2_q;
    rid_p2_d   = vld_p1 ? gid_p1_q : rid_p2_q;

    // State follows next-cycle pipeline occupancy so BUSY lines up with GNT/RVALID.
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant)         state_d = ACTIVE;
        else if (bus.HOLD) state_d = FROZEN;
      end
      ACTIVE: begin
        if (!grant && !vld_p1) state_d = bus.HOLD ? FROZEN : IDLE;
      end
      FROZEN: begin
        if (!bus.HOLD) state_d = grant ? ACTIVE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gnt_p1_q     <= '0;
      mux_sel_p1_q <= '0;
      gid_p1_q     <= '0;
      ptr_q        <= '0;
      vld_p2_q     <= 1'b0;
      rdata_p2_q   <= '0;
      rid_p2_q     <= '0;
      state_q      <= IDLE;
    end else begin
      gnt_p1_q     <= gnt_p1_d;
      mux_sel_p1_q <= mux_sel_p1_d;
      gid_p1_q     <= gid_p1_d;
      ptr_q        <= ptr_d;
      vld_p2_q     <= vld_p2_d;
      rdata_p2_q   <= rdata_p2_d;
      rid_p2_q     <= rid_p2_d;
      state_q      <= state_d;
    end
  end

  assign bus.GNT     = gnt_p1_q;
  assign bus.MUX_SEL = mux_sel_p1_q;
  assign bus.RDATA   = rdata_p2_q;
  assign bus.RVALID  = vld_p2_q;
  assign bus.RID     = rid_p2_q;
  assign bus.BUSY    = (state_q == ACTIVE);
endmodule

// File: doc/regfile_read_arbiter.md
Name: regfile_read_arbiter

Overview:
Shares the single register-file read port (the 16:1 output mux, AL..DI) among N_REQ requesters, such as ALU operand A, ALU operand B, the address unit and debug.
- Round-robin arbitration with a req/gnt handshake.
- Drives the mux select code.
- Captures the mux output and returns it tagged with the requester ID.
- Pipelined: sustains one read per cycle in aggregate.

Parameters:
N_REQ, 4, number of requesters (2..8)
IDW, 2, requester ID width; must be >= clog2(N_REQ)
DW, 16, read data width (matches mux output)
SW, 4, register select code width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
REQ  in  N_REQ  per-requester read request; held until granted
REQ_SEL  in  N_REQ*SW  requester i's register code in bits [i*SW +: SW] (0=AL ... 7=BH, 8=AX ... 15=DI)
HOLD  in  1  freeze: no new grants while high
GNT  out  N_REQ  one-hot grant, registered, high for exactly one cycle per grant
MUX_SEL  out  SW  select code to the read mux, registered
MUX_OUT  in  DW  read mux output (combinational function of MUX_SEL)
RDATA  out  DW  captured read data
RVALID  out  1  RDATA/RID valid, one-cycle pulse per read
RID  out  IDW  index of the requester that owns RDATA
BUSY  out  1  high while a grant or return is in flight

Behaviour:
- Reset values: GNT=0, MUX_SEL=0, RDATA=0, RVALID=0, RID=0, BUSY=0, pointer PTR=0, state IDLE.
- RST asserted asynchronously forces these values immediately. Any in-flight read is discarded and no RVALID is produced for it.
- Arbitration (combinational, evaluated each cycle):
  - Eligible set E = REQ & ~GNT. The requester granted this cycle is masked so its still-high REQ is not re-granted next edge.
  - Search E starting at index PTR, ascending, wrapping at N_REQ-1 -> 0. The first set bit is the winner w.
- Cycle N (rising edge), if E != 0 and HOLD=0:
  - GNT <= onehot(w)
  - MUX_SEL <= REQ_SEL[w]
  - gid <= w
  - PTR <= (w+1) mod N_REQ
- Otherwise GNT <= 0 and MUX_SEL holds its previous value.
- Cycle N+1: GNT is visible and MUX_SEL drives the mux. The requester must drop REQ by the edge ending N+1 unless it wants another read.
- Edge ending N+1:
  - RDATA <= MUX_OUT
  - RID <= gid
  - RVALID <= 1 for one cycle (during cycle N+2)
- Latency: REQ sampled at edge N -> GNT cycle N+1 -> RVALID cycle N+2. Fixed, no stalls.
- Throughput:
  - Aggregate: one grant per cycle.
  - Single requester holding REQ: granted every second cycle, because of the mask.
- RDATA holds its value when RVALID=0. It is updated only on a valid capture.
- State machine:
  - IDLE: no GNT and no RVALID pending; BUSY=0.
  - ACTIVE: GNT or RVALID pipeline stage occupied; BUSY=1.
  - FROZEN: HOLD=1 and pipeline drained; BUSY=0.
- Transitions:
  - IDLE->ACTIVE on a grant.
  - ACTIVE->IDLE when both stages are empty and HOLD=0.
  - ACTIVE->FROZEN when both stages are empty and HOLD=1.
  - FROZEN->IDLE when HOLD falls.
  - IDLE->FROZEN when HOLD=1.
- HOLD rising mid-operation: an in-flight grant still completes with RVALID; no new GNT is issued. PTR is preserved across HOLD.
- REQ_SEL is used only at the grant edge. Changing it after the grant has no effect on that read.
- REQ deasserted before grant: the request is withdrawn and no grant is given.
- All-zero REQ: GNT=0 and PTR is unchanged.

Decomposition:
- Shared package (regfile_pkg):
  - register codes REG_AL=0 ... REG_BH=7, REG_AX=8 ... REG_DI=15
  - SW=4, DW=16
  - state enum {IDLE, ACTIVE, FROZEN}
- One sub-module, rr_arbiter: combinational round-robin pick.
  - Inputs: eligible vector, PTR.
  - Outputs: winner index, any-valid flag.

Test Plan:
1. Mux model returns 16'h1234 for code 4'hB. Only REQ[2]=1 with REQ_SEL[2]=4'hB, dropped on GNT -> GNT=4'b0100 in cycle N+1, MUX_SEL=4'hB; RVALID=1, RDATA=16'h1234, RID=2 in cycle N+2; exactly one RVALID.
2. REQ=4'b1111 held continuously from reset, each requester with a distinct code -> GNT sequence 0001,0010,0100,1000,0001 on consecutive cycles; RVALID high every cycle from the third cycle on; RID sequence 0,1,2,3,0.
3. Only REQ[0] held high -> GNT[0] pulses every other cycle, RVALID every other cycle, never two consecutive grants.
4. PTR=3 (after granting 2); REQ=4'b1001 -> grants go to 3 then 0 (wrap); PTR ends at 1.
5. HOLD raised the cycle after a grant with REQ=4'b0110 pending -> the in-flight read returns RVALID; no GNT while HOLD=1; BUSY=0 once drained; after HOLD falls the next grant follows the saved PTR.
6. RST pulsed asynchronously (mid-cycle) in cycle N+1 of a read -> GNT, RVALID, RDATA, MUX_SEL go to 0 immediately; no RVALID after release; the first post-reset grant goes to the lowest requesting index.
